// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage feeding decode.
//
// Owns the PC and streams sequential word fetches to instruction memory over a
// valid/ready request channel whose responses come back in order. Returned
// words are queued in a DEPTH-entry buffer and handed to decode over a
// valid/ready channel with the opcode/funct3/funct7 fields pre-sliced.
// A taken branch flushes the buffer, retargets the PC and discards every
// response that is still in flight.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   imem_req_*          fetch request channel (valid/ready, word address)
//   imem_resp_*         in-order fetch responses, no backpressure
//   branch_taken/target one-cycle redirect from execute
//   if_valid/if_ready   handshake to decode
//   if_instr/if_pc      buffered instruction and its PC (NOP / resp_pc when empty)
//   if_opcode/funct3/7  fields sliced from if_instr
module fetch_unit #(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int unsigned     DEPTH    = 2
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_resp_valid,
    input  logic [31:0]     imem_resp_data,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] branch_target,
    output logic            if_valid,
    input  logic            if_ready,
    output logic [31:0]     if_instr,
    output logic [XLEN-1:0] if_pc,
    output logic [6:0]      if_opcode,
    output logic [2:0]      if_funct3,
    output logic [6:0]      if_funct7
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam logic [CW:0]     DEPTH_C = (CW + 1)'(DEPTH);
    localparam logic [31:0]     NOP     = 32'h0000_0013;
    localparam logic [XLEN-1:0] STEP    = XLEN'(4);

    // Architectural state
    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] resp_pc;
    logic [CW-1:0]   inflight;
    logic [CW-1:0]   drop;
    logic [CW-1:0]   fifo_count;
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic [XLEN-1:0] pc_mem    [DEPTH];
    logic [31:0]     instr_mem [DEPTH];

    // Per-cycle control
    logic            req_fire;
    logic            resp_fire;
    logic            push;
    logic            pop;
    logic            fifo_empty;
    logic [CW:0]     credit_used;
    logic [CW-1:0]   inflight_after_resp;
    logic [XLEN-1:0] redirect_pc;
    logic [3:0]      unused_low_bits;

    assign unused_low_bits = {branch_target[1:0], fetch_pc[1:0]};

    // Request credit, handshakes and buffer controls
    always_comb begin
        fifo_empty          = (fifo_count == '0);
        credit_used         = {1'b0, fifo_count} + {1'b0, inflight};
        imem_req_valid      = !rst && !branch_taken && (credit_used < DEPTH_C);
        imem_req_addr       = {fetch_pc[XLEN-1:2], 2'b00};
        req_fire            = imem_req_valid && imem_req_ready;
        resp_fire           = !rst && imem_resp_valid;
        inflight_after_resp = inflight - CW'(resp_fire);
        redirect_pc         = {branch_target[XLEN-1:2], 2'b00};
        if_valid            = !rst && !fifo_empty;
        // A redirect wipes the buffer, so same-cycle pushes and pops are void.
        push                = resp_fire && (drop == '0) && !branch_taken;
        pop                 = if_valid && if_ready && !branch_taken;
    end

    // Decode-side view of the buffer head
    always_comb begin
        if_instr = NOP;
        if_pc    = resp_pc;
        if (!fifo_empty) begin
            if_instr = instr_mem[rd_ptr];
            if_pc    = pc_mem[rd_ptr];
        end
        if_opcode = if_instr[6:0];
        if_funct3 = if_instr[14:12];
        if_funct7 = if_instr[31:25];
    end

    // PC, credit and buffer-pointer state
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc   <= RESET_PC;
            resp_pc    <= RESET_PC;
            inflight   <= '0;
            drop       <= '0;
            fifo_count <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
        end else if (branch_taken) begin
            // Everything still outstanding after this cycle belongs to the old path.
            fetch_pc   <= redirect_pc;
            resp_pc    <= redirect_pc;
            inflight   <= inflight_after_resp;
            drop       <= inflight_after_resp;
            fifo_count <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
        end else begin
            if (req_fire) begin
                fetch_pc <= fetch_pc + STEP;
            end
            inflight <= inflight_after_resp + CW'(req_fire);
            if (resp_fire && (drop != '0)) begin
                drop <= drop - CW'(1);
            end
            if (push) begin
                resp_pc <= resp_pc + STEP;
                wr_ptr  <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CW'(1);
                2'b01:   fifo_count <= fifo_count - CW'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Buffer payload storage; contents are only meaningful below fifo_count
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr]    <= resp_pc;
            instr_mem[wr_ptr] <= imem_resp_data;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: behavioural instruction memory with configurable
// latency plus a scoreboard of expected PCs; each delivered instruction is
// checked against the memory contents at its PC.
module tb_fetch_unit;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [6:0]  if_opcode;
    logic [2:0]  if_funct3;
    logic [6:0]  if_funct7;

    always #5 clk = ~clk;

    fetch_unit #(.XLEN(XLEN), .RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_resp_valid(imem_resp_valid),
        .imem_resp_data (imem_resp_data),
        .branch_taken   (branch_taken),
        .branch_target  (branch_target),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .if_opcode      (if_opcode),
        .if_funct3      (if_funct3),
        .if_funct7      (if_funct7)
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    mreq_t       mq[$];      // accepted requests awaiting a response
    logic [31:0] exp_q[$];   // PCs decode is expected to receive, in order
    logic [31:0] exp_addr;   // next request address the bench expects
    int          lat = 1;
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;

    logic        s_req_valid;
    logic        s_req_fire;
    logic        s_if_valid;
    logic [31:0] s_if_pc;
    logic [31:0] s_if_instr;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h0001_0003) ^ 32'h5A5A_0013;
    endfunction

    // One clock: sample just after the negedge, advance to the next negedge,
    // then present any memory response that has come due.
    task automatic cycle();
        mreq_t       m;
        logic [31:0] e;
        logic [31:0] w;
        #1;
        s_req_valid = imem_req_valid;
        s_req_fire  = imem_req_valid && imem_req_ready;
        s_if_valid  = if_valid;
        s_if_pc     = if_pc;
        s_if_instr  = if_instr;
        if (s_req_fire) begin
            total++;
            if (imem_req_addr !== exp_addr) begin
                bad++;
                $display("FAIL req_addr: got %h want %h", imem_req_addr, exp_addr);
            end
            m.addr = imem_req_addr;
            m.due  = cyc + lat;
            mq.push_back(m);
            exp_addr = exp_addr + 32'd4;
            total++;
            if (mq.size() > DEPTH) begin
                bad++;
                $display("FAIL inflight_bound: got %0d want <= %0d", mq.size(), DEPTH);
            end
        end
        if (if_valid && if_ready && !branch_taken) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_out: got pc %h want no output", if_pc);
            end else begin
                e = exp_q.pop_front();
                w = mem_word(e);
                if ({if_pc, if_instr, if_opcode, if_funct3, if_funct7} !==
                    {e, w, w[6:0], w[14:12], w[31:25]}) begin
                    bad++;
                    $display("FAIL out_data: got pc %h instr %h op %h f3 %h f7 %h want pc %h instr %h",
                             if_pc, if_instr, if_opcode, if_funct3, if_funct7, e, w);
                end
            end
        end
        if (rst) mq.delete();
        else if (imem_resp_valid && mq.size() > 0) mq.delete(0);
        @(negedge clk);
        cyc++;
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = mem_word(mq[0].addr);
        end else begin
            imem_resp_valid = 1'b0;
            imem_resp_data  = 32'h0;
        end
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1; branch_taken = 1'b0; if_ready = 1'b0; imem_req_ready = 1'b1;
        repeat (n) cycle();
        rst = 1'b0;
        exp_addr = RESET_PC;
        exp_q.delete();
    endtask

    task automatic drain(input int budget, input string name);
        int n = 0;
        while (exp_q.size() > 0 && n < budget) begin
            cycle();
            n++;
        end
        if_ready = 1'b0;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL %s_timeout: got %0d outputs pending want 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; branch_taken = 1'b0; if_ready = 1'b0; imem_req_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            total++;
            if ({s_req_valid, s_if_valid} !== 2'b00) begin
                bad++;
                $display("FAIL reset_quiet: got req_valid %b if_valid %b want 0 0", s_req_valid, s_if_valid);
            end
        end
        rst = 1'b0;
        exp_addr = RESET_PC;
        exp_q.delete();
        cycle();
        total++;
        if ({s_if_valid, s_if_instr, s_if_pc, s_req_valid} !== {1'b0, NOP, RESET_PC, 1'b1}) begin
            bad++;
            $display("FAIL reset_state: got if_valid %b instr %h pc %h req_valid %b want 0 %h %h 1",
                     s_if_valid, s_if_instr, s_if_pc, s_req_valid, NOP, RESET_PC);
        end
    endtask

    task automatic test_stream();
        int first_req = -1;
        int first_val = -1;
        int n = 0;
        lat = 1;
        do_reset(2);
        if_ready = 1'b1;
        for (int i = 0; i < 6; i++) exp_q.push_back(32'(i * 4));
        while (exp_q.size() > 0 && n < 60) begin
            cycle();
            if (s_req_fire && first_req < 0) first_req = n;
            if (s_if_valid && first_val < 0) first_val = n;
            n++;
        end
        if_ready = 1'b0;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL stream_timeout: got %0d outputs pending want 0", exp_q.size());
            exp_q.delete();
        end
        total++;
        if (first_req != 0 || first_val - first_req != 2) begin
            bad++;
            $display("FAIL stream_latency: got first_req %0d first_valid %0d want 0 2", first_req, first_val);
        end
    endtask

    task automatic test_stall();
        int nreq = 0;
        lat = 1;
        do_reset(2);
        repeat (10) begin
            cycle();
            if (s_req_fire) nreq++;
        end
        total++;
        if (nreq != DEPTH) begin
            bad++;
            $display("FAIL stall_reqs: got %0d want %0d", nreq, DEPTH);
        end
        total++;
        if ({s_if_valid, s_if_pc, s_req_valid} !== {1'b1, 32'h0, 1'b0}) begin
            bad++;
            $display("FAIL stall_hold: got if_valid %b pc %h req_valid %b want 1 00000000 0",
                     s_if_valid, s_if_pc, s_req_valid);
        end
        exp_q.push_back(32'h0); exp_q.push_back(32'h4); exp_q.push_back(32'h8);
        if_ready = 1'b1;
        drain(40, "stall");
    endtask

    task automatic test_ready_toggle();
        int n = 0;
        lat = 1;
        do_reset(2);
        if_ready = 1'b1;
        for (int i = 0; i < 10; i++) exp_q.push_back(32'(i * 4));
        while (exp_q.size() > 0 && n < 100) begin
            imem_req_ready = (n % 2 == 0);
            cycle();
            n++;
        end
        imem_req_ready = 1'b1;
        drain(1, "toggle");
    endtask

    task automatic test_redirect();
        int nreq = 0;
        lat = 3;
        do_reset(2);
        if_ready = 1'b1;
        repeat (2) begin
            cycle();
            if (s_req_fire) nreq++;
        end
        total++;
        if (nreq != 2) begin
            bad++;
            $display("FAIL redirect_setup: got %0d requests want 2", nreq);
        end
        branch_taken = 1'b1; branch_target = 32'h0000_0103; exp_addr = 32'h0000_0100;
        cycle();
        branch_taken = 1'b0;
        total++;
        if (s_req_valid !== 1'b0) begin
            bad++;
            $display("FAIL redirect_noreq: got req_valid %b want 0", s_req_valid);
        end
        exp_q.push_back(32'h100); exp_q.push_back(32'h104); exp_q.push_back(32'h108);
        drain(60, "redirect");
    endtask

    task automatic test_back_to_back();
        lat = 3;
        do_reset(2);
        if_ready = 1'b1;
        repeat (2) cycle();
        branch_taken = 1'b1; branch_target = 32'h0000_0103; exp_addr = 32'h0000_0100;
        cycle();
        // Second redirect lands in the same cycle as the first stale response.
        branch_target = 32'h0000_0200; exp_addr = 32'h0000_0200;
        cycle();
        branch_taken = 1'b0;
        exp_q.push_back(32'h200); exp_q.push_back(32'h204); exp_q.push_back(32'h208);
        drain(60, "b2b");
    endtask

    task automatic test_wrap();
        lat = 1;
        do_reset(2);
        if_ready = 1'b1;
        branch_taken = 1'b1; branch_target = 32'hFFFF_FFFC; exp_addr = 32'hFFFF_FFFC;
        cycle();
        branch_taken = 1'b0;
        exp_q.push_back(32'hFFFF_FFFC); exp_q.push_back(32'h0); exp_q.push_back(32'h4);
        drain(40, "wrap");
    endtask

    task automatic test_reset_mid();
        lat = 3;
        do_reset(2);
        repeat (4) cycle();
        rst = 1'b1;
        cycle();
        total++;
        if ({s_if_valid, s_req_valid} !== 2'b00) begin
            bad++;
            $display("FAIL midreset_quiet: got if_valid %b req_valid %b want 0 0", s_if_valid, s_req_valid);
        end
        rst = 1'b0;
        exp_addr = RESET_PC;
        cycle();
        total++;
        if ({s_if_valid, s_req_fire} !== 2'b01) begin
            bad++;
            $display("FAIL midreset_restart: got if_valid %b req_fire %b want 0 1", s_if_valid, s_req_fire);
        end
        exp_q.push_back(RESET_PC); exp_q.push_back(RESET_PC + 32'd4);
        if_ready = 1'b1;
        drain(40, "midreset");
    endtask

    initial begin
        rst = 1'b1; imem_req_ready = 1'b1; imem_resp_valid = 1'b0; imem_resp_data = 32'h0;
        branch_taken = 1'b0; branch_target = 32'h0; if_ready = 1'b0; exp_addr = RESET_PC;
        @(negedge clk);
        test_reset();
        test_stream();
        test_stall();
        test_ready_toggle();
        test_redirect();
        test_back_to_back();
        test_wrap();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion want finish before 200000");
        $fatal(1, "watchdog expired");
    end

endmodule
